sram_arbiter: RTL and testbench

//  Round-robin arbiter sharing the 16-bit SRAM Avalon slave (1-cycle write, 2-cycle read) between NUM_MASTERS requesters.

---
 rtl/sram_arb_pkg.sv | 27 ++
 rtl/sram_arb_if.sv | 39 +++
 rtl/sram_arb_rr_grant.sv | 39 +++
 rtl/sram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared widths, request/tag records and pointer helper for the SRAM round-robin arbiter.
package sram_arb_pkg;

  localparam int SRAM_AW  = 18;
  localparam int SRAM_DW  = 16;
  localparam int SRAM_BEW = 2;
  localparam int ID_W     = 2;

  typedef struct packed {
    logic [SRAM_AW-1:0]  addr;
    logic [SRAM_BEW-1:0] be;
    logic                rd;
    logic                wr;
    logic [SRAM_DW-1:0]  wdata;
  } sram_req_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id,
                                               input logic [ID_W-1:0] last_id);
    return (id == last_id) ? {ID_W{1'b0}} : id + 2'd1;
  endfunction

endpackage

// File: rtl/sram_arb_if.sv
// Master-side Avalon bundle plus SRAM slave-side signals seen by the arbiter.
interface sram_arb_if
  import sram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
);

  logic [SRAM_AW*NUM_MASTERS-1:0]  m_address;
  logic [SRAM_BEW*NUM_MASTERS-1:0] m_byteenable;
  logic [NUM_MASTERS-1:0]          m_read;
  logic [NUM_MASTERS-1:0]          m_write;
  logic [SRAM_DW*NUM_MASTERS-1:0]  m_writedata;
  logic [NUM_MASTERS-1:0]          m_waitrequest;
  logic [SRAM_DW-1:0]              m_readdata;
  logic [NUM_MASTERS-1:0]          m_readdatavalid;

  logic [SRAM_AW-1:0]              s_address;
  logic [SRAM_BEW-1:0]             s_byteenable;
  logic                            s_chipselect;
  logic                            s_read;
  logic                            s_write;
  logic [SRAM_DW-1:0]              s_writedata;
  logic [SRAM_DW-1:0]              s_readdata;

  // Arbiter view: accepts master requests, drives the SRAM.
  modport slave (
    input  m_address, m_byteenable, m_read, m_write, m_writedata, s_readdata,
    output m_waitrequest, m_readdata, m_readdatavalid,
           s_address, s_byteenable, s_chipselect, s_read, s_write, s_writedata
  );

  // Environment view: requesters and the SRAM device.
  modport master (
    output m_address, m_byteenable, m_read, m_write, m_writedata, s_readdata,
    input  m_waitrequest, m_readdata, m_readdatavalid,
           s_address, s_byteenable, s_chipselect, s_read, s_write, s_writedata
  );

endinterface

// File: rtl/sram_arb_rr_grant.sv
// Combinational round-robin pick: first eligible requester at or after the pointer.
module sram_arb_rr_grant
  import sram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [ID_W-1:0]        gnt_id,
  output logic                   gnt_valid
);

  int   idx_s;
  logic hit_s;

  // Scan from the farthest offset down so the nearest hit to the pointer wins.
  always_comb begin
    gnt_id    = {ID_W{1'b0}};
    gnt_valid = 1'b0;
    idx_s     = 0;
    hit_s     = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx_s     = (int'(ptr) + k) % NUM_MASTERS;
      hit_s     = req[idx_s];
      gnt_id    = hit_s ? ID_W'(idx_s) : gnt_id;
      gnt_valid = hit_s | gnt_valid;
    end
  end

  // Expand the encoded winner to a one-hot grant.
  always_comb begin
    gnt = {NUM_MASTERS{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      gnt[i] = gnt_valid & (gnt_id == ID_W'(i));
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin SRAM arbiter with read->write turnaround and tagged read return.
// Optional per-master grant counters when SRAM_ARB_PERF_EN is defined.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_MASTERS  = 2,
  parameter int READ_LATENCY = 2,
  parameter int TURNAROUND   = 1
) (
  input  logic       clk,
  input  logic       reset,
  sram_arb_if.slave  bus
`ifdef SRAM_ARB_PERF_EN
  ,
  input  logic                      perf_clear,
  output logic [32*NUM_MASTERS-1:0] perf_grants
`endif
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_MASTERS - 1);
  localparam int              TA_W    = (TURNAROUND < 2) ? 1 : $clog2(TURNAROUND + 1);
  localparam logic [TA_W-1:0] TA_LOAD = TA_W'(TURNAROUND);

  sram_req_t              req_s [NUM_MASTERS];
  sram_req_t              sel_s;
  logic [NUM_MASTERS-1:0] elig_s;
  logic [NUM_MASTERS-1:0] gnt_s;
  logic [ID_W-1:0]        gnt_id_s;
  logic                   gnt_valid_s;
  logic                   rd_accept_s;
  logic                   ta_idle_s;
  logic [NUM_MASTERS-1:0] rdv_s;

  logic [ID_W-1:0]        rr_ptr_r;
  logic [TA_W-1:0]        ta_cnt_r;
  rd_tag_t                tag_r [READ_LATENCY];

  assign ta_idle_s = (ta_cnt_r == {TA_W{1'b0}});

  // Unpack master fields; write beats read on the same master, writes wait out turnaround.
  always_comb begin
    elig_s = {NUM_MASTERS{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req_s[i].addr  = bus.m_address[SRAM_AW*i +: SRAM_AW];
      req_s[i].be    = bus.m_byteenable[SRAM_BEW*i +: SRAM_BEW];
      req_s[i].rd    = bus.m_read[i];
      req_s[i].wr    = bus.m_write[i];
      req_s[i].wdata = bus.m_writedata[SRAM_DW*i +: SRAM_DW];
      elig_s[i]      = ~reset & ((req_s[i].wr & ta_idle_s) | (req_s[i].rd & ~req_s[i].wr));
    end
  end

  sram_arb_rr_grant #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_grant (
    .req       (elig_s),
    .ptr       (rr_ptr_r),
    .gnt       (gnt_s),
    .gnt_id    (gnt_id_s),
    .gnt_valid (gnt_valid_s)
  );

  // Select the granted master's request; all-zero when nobody is granted.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sel_s = gnt_s[i] ? req_s[i] : sel_s;
    end
  end

  assign rd_accept_s = gnt_valid_s & ~sel_s.wr;

  // Slave drive and master handshake.
  always_comb begin
    bus.m_waitrequest = ~gnt_s;
    bus.s_address     = sel_s.addr;
    bus.s_byteenable  = sel_s.be;
    bus.s_writedata   = sel_s.wdata;
    bus.s_chipselect  = gnt_valid_s;
    bus.s_write       = gnt_valid_s & sel_s.wr;
    bus.s_read        = rd_accept_s;
    bus.m_readdata    = bus.s_readdata;
  end

  // Return qualifier from the oldest tag stage.
  always_comb begin
    rdv_s = {NUM_MASTERS{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rdv_s[i] = ~reset & tag_r[READ_LATENCY-1].valid &
                 (tag_r[READ_LATENCY-1].id == ID_W'(i));
    end
    bus.m_readdatavalid = rdv_s;
  end

  // Tag pipe follows the slave read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        tag_r[k] <= '0;
      end
    end else begin
      tag_r[0] <= {rd_accept_s, (rd_accept_s ? gnt_id_s : {ID_W{1'b0}})};
      for (int k = 1; k < READ_LATENCY; k++) begin
        tag_r[k] <= tag_r[k-1];
      end
    end
  end

  // Round-robin pointer advances past the winner on each accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= {ID_W{1'b0}};
    end else if (gnt_valid_s) begin
      rr_ptr_r <= rr_next(gnt_id_s, LAST_ID);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Turnaround counter: reloaded by every read accept, drains one per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ta_cnt_r <= {TA_W{1'b0}};
    end else if (rd_accept_s) begin
      ta_cnt_r <= TA_LOAD;
    end else if (!ta_idle_s) begin
      ta_cnt_r <= ta_cnt_r - TA_W'(1);
    end else begin
      ta_cnt_r <= ta_cnt_r;
    end
  end

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_cnt_r [NUM_MASTERS];

  // Accepted-transfer counters; a clear overrides a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || perf_clear) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        perf_cnt_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        perf_cnt_r[i] <= perf_cnt_r[i] + {31'd0, gnt_s[i]};
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    perf_grants = {(32*NUM_MASTERS){1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      perf_grants[32*i +: 32] = perf_cnt_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench for sram_arbiter: a spec-level model predicts each
// cycle's grant and slave drive, and queues expected read returns for a separate monitor.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int N     = 3;
  localparam int RL    = 2;
  localparam int TA    = 1;
  localparam int TOTAL = 900;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_arb_if #(.NUM_MASTERS(N)) bus ();

`ifdef SRAM_ARB_PERF_EN
  logic              perf_clear = 1'b0;
  logic [32*N-1:0]   perf_grants;
  int unsigned       perf_model [N];
`endif

  sram_arbiter #(
    .NUM_MASTERS  (N),
    .READ_LATENCY (RL),
    .TURNAROUND   (TA)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_clear  (perf_clear),
    .perf_grants (perf_grants)
`endif
  );

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sbq [$];
  int          errors = 0;
  int          checks = 0;
  int          cycle  = -1;

  // Stimulus state per master
  bit          act  [N];
  bit          isw  [N];
  bit          both [N];
  logic [17:0] maddr [N];
  logic [1:0]  mbe  [N];
  logic [15:0] mwd  [N];
  bit          acc_obs [N];

  // Reference model state
  int          m_ptr = 0;
  int          m_ta  = 0;
  logic [15:0] ref_mem [16];

  function automatic logic [15:0] init_word(input int i);
    logic [15:0] w;
    w = 16'hA5A5 ^ (16'(i) * 16'h0101);
    return w;
  endfunction

  // SRAM device: 1-cycle write, 2-cycle read
  logic [15:0] slv_mem [16];
  logic [15:0] slv_p1;
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (bus.s_chipselect && bus.s_write) begin
      if (bus.s_byteenable[0]) slv_mem[bus.s_address[3:0]][7:0]  <= bus.s_writedata[7:0];
      if (bus.s_byteenable[1]) slv_mem[bus.s_address[3:0]][15:8] <= bus.s_writedata[15:8];
    end
    if (bus.s_chipselect && bus.s_read) slv_p1 <= slv_mem[bus.s_address[3:0]];
    bus.s_readdata <= slv_p1;
  end

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      bus.m_read[i]               = act[i] & (~isw[i] | both[i]);
      bus.m_write[i]              = act[i] & isw[i];
      bus.m_address[18*i +: 18]   = maddr[i];
      bus.m_byteenable[2*i +: 2]  = mbe[i];
      bus.m_writedata[16*i +: 16] = mwd[i];
    end
  endtask

  task automatic new_req(input int i, input bit w);
    act[i]   = 1'b1;
    isw[i]   = w;
    both[i]  = w && ($urandom % 32 == 0);
    maddr[i] = 18'($urandom);
    mbe[i]   = 2'($urandom_range(1, 3));
    mwd[i]   = 16'($urandom);
  endtask

  // Model: predict grant and slave drive, compare, then advance state
  always @(negedge clk) begin
    int                 g;
    int                 i;
    logic [N-1:0]       exp_wait;
    logic [38:0]        exp_slv;
    logic [38:0]        act_slv;
    #1;
    g = -1;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (g < 0 && act[i] && ((isw[i] && m_ta == 0) || !isw[i])) g = i;
      end
    end
    exp_wait = '1;
    exp_slv  = '0;
    if (g >= 0) begin
      exp_wait[g] = 1'b0;
      exp_slv = {maddr[g], mbe[g], 1'b1, ~isw[g], isw[g], mwd[g]};
    end
    act_slv = {bus.s_address, bus.s_byteenable, bus.s_chipselect, bus.s_read,
               bus.s_write, bus.s_writedata};
    checks++;
    if (bus.m_waitrequest !== exp_wait) begin
      errors++;
      $display("FAIL waitrequest cycle=%0d got=%b want=%b", cycle, bus.m_waitrequest, exp_wait);
    end
    checks++;
    if (act_slv !== exp_slv) begin
      errors++;
      $display("FAIL slave_bus cycle=%0d got=%h want=%h", cycle, act_slv, exp_slv);
    end
`ifdef SRAM_ARB_PERF_EN
    for (int m = 0; m < N; m++) begin
      checks++;
      if (perf_grants[32*m +: 32] !== perf_model[m]) begin
        errors++;
        $display("FAIL perf_grants[%0d] cycle=%0d got=%0d want=%0d", m, cycle,
                 perf_grants[32*m +: 32], perf_model[m]);
      end
    end
`endif
    for (int m = 0; m < N; m++) acc_obs[m] = act[m] && !bus.m_waitrequest[m];

    if (reset) begin
      m_ptr = 0;
      m_ta  = 0;
`ifdef SRAM_ARB_PERF_EN
      for (int m = 0; m < N; m++) perf_model[m] = 0;
`endif
    end else begin
`ifdef SRAM_ARB_PERF_EN
      if (g >= 0) perf_model[g]++;
      if (perf_clear) for (int m = 0; m < N; m++) perf_model[m] = 0;
`endif
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (isw[g]) begin
          if (mbe[g][0]) ref_mem[maddr[g][3:0]][7:0]  = mwd[g][7:0];
          if (mbe[g][1]) ref_mem[maddr[g][3:0]][15:8] = mwd[g][15:8];
        end else begin
          sbq.push_back('{id: g, data: ref_mem[maddr[g][3:0]], due: cycle + RL});
        end
      end
      if (g >= 0 && !isw[g]) m_ta = TA;
      else if (m_ta > 0) m_ta--;
    end
  end

  // Monitor: pop the scoreboard whenever the DUT presents return data
  always @(negedge clk) begin
    logic [N-1:0] oh;
    exp_t         e;
    if (reset) begin
      sbq.delete();
      checks++;
      if (bus.m_readdatavalid !== '0) begin
        errors++;
        $display("FAIL rdv_in_reset cycle=%0d got=%b want=0", cycle, bus.m_readdatavalid);
      end
    end else if (bus.m_readdatavalid !== '0) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rdv cycle=%0d got=%b want=none", cycle, bus.m_readdatavalid);
      end else begin
        e  = sbq.pop_front();
        oh = '0;
        oh[e.id] = 1'b1;
        if (bus.m_readdatavalid !== oh || bus.m_readdata !== e.data || e.due != cycle) begin
          errors++;
          $display("FAIL read_return cycle=%0d got rdv=%b data=%h want rdv=%b data=%h due=%0d",
                   cycle, bus.m_readdatavalid, bus.m_readdata, oh, e.data, e.due);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cycle) begin
      checks++;
      errors++;
      $display("FAIL missing_rdv cycle=%0d got=none want id=%0d data=%h", cycle, sbq[0].id, sbq[0].data);
      void'(sbq.pop_front());
    end
  end

  // Driver: phases of directed, mixed, read-streaming and write-heavy traffic
  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < N; i++) begin
      act[i] = 0; isw[i] = 0; both[i] = 0; acc_obs[i] = 0;
      maddr[i] = '0; mbe[i] = '0; mwd[i] = '0;
    end
    bus.m_address = '0; bus.m_byteenable = '0; bus.m_read = '0;
    bus.m_write = '0; bus.m_writedata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    for (int c = 0; c < TOTAL + 6; c++) begin
      @(posedge clk);
      #1;
      cycle = c;
      reset = (c >= 200 && c < 202);
`ifdef SRAM_ARB_PERF_EN
      perf_clear = (c == 700 || c == 705);
`endif
      for (int i = 0; i < N; i++) begin
        if (act[i] && acc_obs[i]) act[i] = 0;
        if (c == 0 && i == 0) begin
          new_req(0, 1'b0);
          maddr[0] = 18'h00010;
          both[0]  = 1'b0;
        end else if (c < 6 || c >= TOTAL) begin
          act[i] = 0;
        end else if (c >= 400 && c < 600) begin
          if (!act[i]) new_req(i, 1'b0);
        end else if (!act[i]) begin
          if (c < 400 && $urandom % 4 == 0) new_req(i, 1'($urandom % 2));
          else if (c >= 600 && $urandom % 2 == 0) new_req(i, ($urandom % 3) != 0);
        end else if ($urandom % 32 == 0) begin
          act[i] = 0;
        end
      end
      drive_bus();
    end
    @(negedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain cycle=%0d got=%0d pending want=0", cycle, sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
